// File: rtl/input_conditioner_pkg.sv
// Shared constants for the pushbutton/switch input conditioner.
package input_conditioner_pkg;

  // Board idle levels: keys are active-low and switches are active-high.
  localparam logic KEY_IDLE = 1'b1;
  localparam logic SW_IDLE  = 1'b0;

  // 20 ms at 50 MHz for hardware; a short window keeps simulation fast.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int SIM_DEBOUNCE_CYCLES     = 16;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : input_conditioner_pkg

// File: rtl/debounce_bit.sv
// One-bit synchroniser plus counter debouncer with registered edge pulses.
// A new level must be seen at the synchroniser output for DEBOUNCE_CYCLES
// consecutive cycles before it becomes the clean level. Any return to the
// current clean level restarts the count; the counter never wraps.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = SW_IDLE
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Plain shift-register synchroniser; no logic between stages.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Next-state for the persistence counter, clean level and edge pulses.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_s == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      // Level has persisted long enough: accept it and flag the direction.
      stable_d = sync_s;
      cnt_d    = CNT_ZERO;
      rise_d   = sync_s;
      fall_d   = ~sync_s;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers; pulses update on the same edge as the level.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q    <= CNT_ZERO;
      stable_q <= IDLE_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign clean = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule : debounce_bit

// File: rtl/input_conditioner.sv
// Conditions raw DE2 pushbuttons and slide switches for the PIO inputs and
// emits single-cycle press/release/change events. Reset deassertion is
// expected to be synchronised by the enclosing top level.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_KEYS          = 3,
  parameter int N_SW            = 18,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [N_KEYS-1:0] keys_raw,
  input  logic [N_SW-1:0]   switches_raw,
  output logic [N_KEYS-1:0] keys_clean,
  output logic [N_SW-1:0]   switches_clean,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              sw_changed
);

  logic [N_SW-1:0] sw_rise_s;
  logic [N_SW-1:0] sw_fall_s;

  // Keys are active-low: a falling clean level is a press.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (KEY_IDLE)
    ) u_debounce (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .raw        (keys_raw[i]),
      .clean      (keys_clean[i]),
      .rise       (key_release[i]),
      .fall       (key_press[i])
    );
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (SW_IDLE)
    ) u_debounce (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .raw        (switches_raw[j]),
      .clean      (switches_clean[j]),
      .rise       (sw_rise_s[j]),
      .fall       (sw_fall_s[j])
    );
  end

  // Pulses are already registered, so any number of simultaneous switch
  // changes collapses into one aligned single-cycle event.
  assign sw_changed = |(sw_rise_s | sw_fall_s);

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a short debounce window.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int NK = 3;
  localparam int NS = 18;
  localparam int NB = NK + NS;
  localparam int SS = 2;
  localparam int DC = SIM_DEBOUNCE_CYCLES;
  localparam logic [NB-1:0] IDLE_V = {{NK{KEY_IDLE}}, {NS{SW_IDLE}}};
  localparam logic [27:0] RESET_OUT = {3'b111, 18'h0, 3'b000, 3'b000, 1'b0};

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic [NK-1:0] keys_raw;
  logic [NS-1:0] switches_raw;
  logic [NK-1:0] keys_clean;
  logic [NS-1:0] switches_clean;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          sw_changed;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw samples delayed through an SS-deep pipe, then a
  // level is accepted once it has differed from the accepted level for DC
  // consecutive cycles.
  logic [NB-1:0] pipe_m [SS];
  logic [NB-1:0] acc_m;
  logic [NB-1:0] rise_m;
  logic [NB-1:0] fall_m;
  int            run_m [NB];

  input_conditioner #(
    .N_KEYS         (NK),
    .N_SW           (NS),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .keys_raw      (keys_raw),
    .switches_raw  (switches_raw),
    .keys_clean    (keys_clean),
    .switches_clean(switches_clean),
    .key_press     (key_press),
    .key_release   (key_release),
    .sw_changed    (sw_changed)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [27:0] observed();
    return {keys_clean, switches_clean, key_press, key_release, sw_changed};
  endfunction

  function automatic logic [27:0] expected();
    logic [NS-1:0] sw_ev;
    sw_ev = rise_m[NS-1:0] | fall_m[NS-1:0];
    return {acc_m, fall_m[NB-1:NS], rise_m[NB-1:NS], |sw_ev};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SS; s++) pipe_m[s] = IDLE_V;
    acc_m  = IDLE_V;
    rise_m = '0;
    fall_m = '0;
    for (int b = 0; b < NB; b++) run_m[b] = 0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] sync_v;
    if (reset_reset) begin
      model_reset();
    end else begin
      sync_v = pipe_m[SS-1];
      for (int s = SS-1; s > 0; s--) pipe_m[s] = pipe_m[s-1];
      pipe_m[0] = {keys_raw, switches_raw};
      rise_m = '0;
      fall_m = '0;
      for (int b = 0; b < NB; b++) begin
        if (sync_v[b] == acc_m[b]) begin
          run_m[b] = 0;
        end else begin
          run_m[b] = run_m[b] + 1;
          if (run_m[b] == DC) begin
            acc_m[b] = sync_v[b];
            run_m[b] = 0;
            if (sync_v[b]) rise_m[b] = 1'b1;
            else           fall_m[b] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    keys_raw     = 3'b000;
    switches_raw = 18'($urandom()) | 18'h1;
    for (int k = 0; k < DC + 6; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL reset_pre cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
    end
    #3 reset_reset = 1'b1;
    #1;
    n_checks++;
    if (observed() !== RESET_OUT) $display("FAIL reset_async: got %h want %h", observed(), RESET_OUT);
    else n_pass++;
    model_reset();
    step();
    step();
    keys_raw     = 3'b111;
    switches_raw = 18'h0;
    reset_reset  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      n_checks++;
      if (observed() !== RESET_OUT) $display("FAIL reset_post cyc %0d: got %h want %h", k, observed(), RESET_OUT);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int press_at = -1;
    int n_ev     = 0;
    keys_raw[0] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL press_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (key_press[0]) begin n_ev++; press_at = k; end
    end
    n_checks++;
    if (press_at != SS + DC || n_ev != 1) $display("FAIL press_latency: got cycle %0d count %0d want cycle %0d count 1", press_at, n_ev, SS + DC);
    else n_pass++;
    press_at = -1;
    n_ev     = 0;
    keys_raw[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL release_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (key_release[0]) begin n_ev++; press_at = k; end
    end
    n_checks++;
    if (press_at != SS + DC || n_ev != 1) $display("FAIL release_latency: got cycle %0d count %0d want cycle %0d count 1", press_at, n_ev, SS + DC);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int bounce_ev = 0;
    int press_at  = -1;
    for (int seg = 0; seg < 12; seg++) begin
      keys_raw[1] = (seg % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 5; k++) begin
        step();
        n_checks++;
        if (observed() !== expected()) $display("FAIL bounce_model seg %0d: got %h want %h", seg, observed(), expected());
        else n_pass++;
        if (key_press[1]) bounce_ev++;
      end
    end
    n_checks++;
    if (bounce_ev != 0) $display("FAIL bounce_reject: got %0d presses want 0", bounce_ev);
    else n_pass++;
    keys_raw[1] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL bounce_hold cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (key_press[1]) press_at = k;
    end
    n_checks++;
    if (press_at != SS + DC) $display("FAIL bounce_latency: got cycle %0d want %0d", press_at, SS + DC);
    else n_pass++;
    keys_raw[1] = 1'b1;
    repeat (24) step();
  endtask

  task automatic test_simultaneous();
    int ev_at = -1;
    int n_ev  = 0;
    switches_raw = 18'h20001;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL simul_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (sw_changed) begin n_ev++; ev_at = k; end
    end
    n_checks++;
    if (ev_at != SS + DC || n_ev != 1 || switches_clean !== 18'h20001)
      $display("FAIL simul_event: got cycle %0d count %0d sw %h want cycle %0d count 1 sw 20001", ev_at, n_ev, switches_clean, SS + DC);
    else n_pass++;
    switches_raw = 18'h0;
    repeat (24) step();
  endtask

  task automatic test_glitch();
    int n_ev = 0;
    switches_raw[5] = 1'b1;
    for (int k = 0; k < 35; k++) begin
      if (k == DC - 1) switches_raw[5] = 1'b0;
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL glitch_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (sw_changed) n_ev++;
    end
    n_checks++;
    if (n_ev != 0 || switches_clean !== 18'h0) $display("FAIL glitch_reject: got %0d events sw %h want 0 events sw 0", n_ev, switches_clean);
    else n_pass++;
  endtask

  task automatic test_reset_mid_count();
    int press_at = -1;
    keys_raw[2] = 1'b0;
    repeat (10) step();
    #2 reset_reset = 1'b1;
    #1;
    n_checks++;
    if (keys_clean[2] !== 1'b1 || key_press !== 3'b000) $display("FAIL midreset_hold: got clean %b press %b want 1 000", keys_clean[2], key_press);
    else n_pass++;
    model_reset();
    step();
    step();
    reset_reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (observed() !== expected()) $display("FAIL midreset_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
      if (key_press[2]) press_at = k;
    end
    n_checks++;
    if (press_at != SS + DC) $display("FAIL midreset_latency: got cycle %0d want %0d", press_at, SS + DC);
    else n_pass++;
    keys_raw = 3'b111;
    repeat (24) step();
  endtask

  task automatic test_random();
    int b;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        b = $urandom_range(0, NB - 1);
        if (b >= NS) keys_raw[b-NS] = ~keys_raw[b-NS];
        else         switches_raw[b] = ~switches_raw[b];
      end
      if ($urandom_range(0, 399) == 0) begin
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
      end else begin
        step();
      end
      n_checks++;
      if (observed() !== expected()) $display("FAIL random_model cyc %0d: got %h want %h", k, observed(), expected());
      else n_pass++;
    end
  endtask

  // Test sequence.
  initial begin
    reset_reset  = 1'b1;
    keys_raw     = 3'b111;
    switches_raw = 18'h0;
    model_reset();
    repeat (3) step();
    reset_reset = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_glitch();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_input_conditioner

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw DE2 pushbuttons and slide switches before they reach the GameSystem PIO inputs (keys_export, switches_export).
- Per-bit 2-FF synchronisation, then counter-based debounce.
- Also produces single-cycle press/release/change event pulses for fabric-side logic (e.g. a game-tick/interrupt source).
- Sits directly upstream of the Qsys system instance in the top level.

Parameters:
- N_KEYS, 3, number of pushbuttons (active-low on the board).
- N_SW, 18, number of slide switches (active-high).
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 1000000, cycles a new level must persist before it is accepted (20 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk_clk  input  1  system clock, 50 MHz
- reset_reset  input  1  asynchronous, active-high reset
- keys_raw  input  N_KEYS  raw pushbuttons, asynchronous, 0 = pressed
- switches_raw  input  N_SW  raw slide switches, asynchronous
- keys_clean  output  N_KEYS  debounced keys, active-low; drives keys_export
- switches_clean  output  N_SW  debounced switches; drives switches_export
- key_press  output  N_KEYS  1-cycle pulse per key on accepted 1->0 transition
- key_release  output  N_KEYS  1-cycle pulse per key on accepted 0->1 transition
- sw_changed  output  1  1-cycle pulse when any switches_clean bit changes

Behaviour:
- Reset is asynchronous assert, synchronous deassert. Deassertion synchronisation is done at top level, not here.
- Reset values:
  - keys_clean = all 1s; switches_clean = all 0s.
  - key_press = 0, key_release = 0, sw_changed = 0.
  - Key synchroniser flops = 1; switch synchroniser flops = 0.
  - All debounce counters = 0.
- Synchroniser: SYNC_STAGES flops per bit. Its output is sync[i]. No logic between the stages.
- Debounce, per bit, one counter cnt[i] and one stable flop stable[i]:
  - If sync[i] == stable[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else: cnt <= cnt + 1.
- Any glitch back to the stable level before the count completes restarts the count from 0. The counter never wraps.
- Latency: a raw level held constant appears on the clean output exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first sampling edge. A pulse shorter than DEBOUNCE_CYCLES cycles at sync never propagates.
- Outputs are registered directly from the stable flops; keys_clean = stable for key bits.
- Event pulses:
  - key_press[i] is high in the same cycle keys_clean[i] first reads 0, for exactly one cycle. It is registered alongside stable; compute it as the transition condition, not as a delayed edge detect.
  - key_release[i] is the same for a 0->1 transition.
  - sw_changed is the OR of all switch-bit transition conditions in that cycle. Multiple simultaneous switch changes give a single 1-cycle pulse.
- Simultaneous events: bits are fully independent. Several keys may pulse in the same cycle.
- Reset mid-count: counters clear and outputs return to reset values immediately. No event pulse is generated on reset entry or exit.
- Post-reset: if a key is physically held at reset release, it is accepted after SYNC_STAGES + DEBOUNCE_CYCLES cycles and generates key_press. This is intended.

Decomposition:
- Package input_conditioner_pkg holds:
  - Default constants: KEY_IDLE = 1'b1, SW_IDLE = 1'b0, DEFAULT_DEBOUNCE_CYCLES = 1000000.
  - A simulation override constant SIM_DEBOUNCE_CYCLES = 16.
- Sub-module debounce_bit:
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, IDLE_LEVEL.
  - Ports: clk_clk, reset_reset, raw, clean, rise, fall.
  - Instantiated N_KEYS + N_SW times via generate.
  - The top computes key_press/key_release from fall/rise and ORs the switch rise|fall pulses into sw_changed.

Test Plan (DEBOUNCE_CYCLES=16, SYNC_STAGES=2):
- Reset: assert reset_reset asynchronously mid-cycle -> keys_clean=3'b111, switches_clean=18'h0, all pulses 0 immediately; nothing pulses after release with keys_raw=3'b111.
- Clean press: keys_raw[0] 1->0 held -> keys_clean[0]=0 and key_press=3'b001 for one cycle exactly 18 cycles after the change; key_release stays 0.
- Bounce: keys_raw[1] toggles with 5-cycle low/high periods for 60 cycles, then holds 0 -> no key_press during bouncing; key_press[1] fires 18 cycles after the final hold starts.
- Simultaneous: switches_raw 0 -> 18'h20001 in one edge -> switches_clean=18'h20001 after 18 cycles; sw_changed high exactly one cycle.
- Glitch rejection: switches_raw[5] high for 15 cycles, then low -> switches_clean unchanged, sw_changed never asserts.
- Reset mid-count: keys_raw[2]=0 for 10 cycles, pulse reset, keep keys_raw[2]=0 -> keys_clean[2]=1 during reset; key_press[2] fires 18 cycles after reset release.
